// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: iterative radix-4 Booth multiplier sequencer for the MIPS
// MULT/MULTU path. It retires one Booth digit per cycle into a 2*WIDTH+2 bit
// accumulator and delivers the 2*WIDTH bit {Hi,Lo} product.
//
// Ports:
//   Clk, Reset     clock, synchronous active-high reset
//   Start          request a multiply (accepted in IDLE or DONE only)
//   Signed         1 = MULT (two's complement), 0 = MULTU
//   A, B           multiplicand / multiplier, sampled with an accepted Start
//   Busy           high while digits are being retired
//   Done           one-cycle pulse; Product is valid from this cycle
//   Product        {Hi,Lo}, held until overwritten by the next operation
//   PPSel, PPNeg   partial-product select (00=0, 01=M, 10=2M) and negate,
//                  combinational from the current digit; idle value 00/0
module booth_mult_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Signed,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product,
  output logic [1:0]           PPSel,
  output logic                 PPNeg
);

  localparam int unsigned NITER = WIDTH / 2 + 1;
  localparam int unsigned ACCW  = 2 * WIDTH + 2;
  localparam int unsigned QW    = WIDTH + 3;
  localparam int unsigned CNTW  = $clog2(NITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [CNTW-1:0]  iterCnt;
  logic [ACCW-1:0]  mShift;    // M * 4^k, pre-extended to accumulator width
  logic [QW-1:0]    qShift;    // extended multiplier with Q[-1] = 0 at bit 0
  logic [ACCW-1:0]  acc;

  logic             loadOps;
  logic             lastIter;
  logic [ACCW-1:0]  aExt;
  logic [QW-1:0]    qInit;
  logic [ACCW-1:0]  ppVal;
  logic [ACCW-1:0]  accNext;

  // Operand extension: sign bits only fill when Signed is set.
  assign aExt     = {{(ACCW - WIDTH){Signed & A[WIDTH-1]}}, A};
  assign qInit    = {{2{Signed & B[WIDTH-1]}}, B, 1'b0};
  assign lastIter = (iterCnt == CNTW'(NITER - 1));

  // Next state, operand load strobe and Booth digit decode.
  always_comb begin
    nextState = state;
    loadOps   = 1'b0;
    PPSel     = 2'b00;
    PPNeg     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          nextState = RUN;
          loadOps   = 1'b1;
        end
      end
      RUN: begin
        // qShift[2:0] = (Q[2k+1], Q[2k], Q[2k-1]) for the current digit k
        case (qShift[2:0])
          3'b001, 3'b010: begin PPSel = 2'b01; PPNeg = 1'b0; end
          3'b011:         begin PPSel = 2'b10; PPNeg = 1'b0; end
          3'b100:         begin PPSel = 2'b10; PPNeg = 1'b1; end
          3'b101, 3'b110: begin PPSel = 2'b01; PPNeg = 1'b1; end
          default:        begin PPSel = 2'b00; PPNeg = 1'b0; end
        endcase
        if (lastIter) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (Start) begin
          nextState = RUN;
          loadOps   = 1'b1;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Partial product selected by the digit, then added or subtracted.
  always_comb begin
    ppVal = '0;
    case (PPSel)
      2'b01:   ppVal = mShift;
      2'b10:   ppVal = {mShift[ACCW-2:0], 1'b0};
      default: ppVal = '0;
    endcase
    accNext = PPNeg ? (acc - ppVal) : (acc + ppVal);
  end

  // State register and datapath.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      iterCnt <= '0;
      mShift  <= '0;
      qShift  <= '0;
      acc     <= '0;
      Product <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state <= nextState;
      Busy  <= (nextState == RUN);
      Done  <= (nextState == DONE);
      if (loadOps) begin
        mShift  <= aExt;
        qShift  <= qInit;
        acc     <= '0;
        iterCnt <= '0;
      end else if (state == RUN) begin
        acc     <= accNext;
        mShift  <= {mShift[ACCW-3:0], 2'b00};
        qShift  <= {2'b00, qShift[QW-1:2]};
        iterCnt <= iterCnt + CNTW'(1);
        if (lastIter) begin
          Product <= accNext[2*WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb_booth_mult_ctrl: directed plus randomized checks of booth_mult_ctrl
// against a plain-arithmetic product model. The select outputs are checked by
// rebuilding the multiplier value from the observed digits.
module tb_booth_mult_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Signed;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [63:0] Product;
  logic [1:0]  PPSel;
  logic        PPNeg;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] lastProd = '0;

  booth_mult_ctrl #(.WIDTH(32)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Signed  (Signed),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product),
    .PPSel   (PPSel),
    .PPNeg   (PPNeg)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] refProd(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint va;
    longint vb;
    va = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    vb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    return 64'(va * vb);
  endfunction

  function automatic longint refMult(input logic sgn, input logic [31:0] b);
    return sgn ? longint'($signed(b)) : longint'({32'd0, b});
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Present operands with Start for exactly one sampling edge.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    Signed = sgn;
    A      = a;
    B      = b;
    Start  = 1'b1;
    tick();
    Start  = 1'b0;
  endtask

  // Follow one operation from its first RUN cycle to the Done cycle.
  // glitch >= 0 re-asserts Start with junk operands in that RUN cycle.
  task automatic waitResult(input string tag, input logic sgn, input logic [31:0] a,
                            input logic [31:0] b, input int glitch);
    logic [63:0] expP;
    longint      digSum;
    longint      d;
    int          n;
    int          doneSeen;
    expP     = refProd(sgn, a, b);
    digSum   = 0;
    n        = 0;
    doneSeen = 0;
    chk({tag, "_busy_first"}, 64'(Busy), 64'd1);
    chk({tag, "_prod_held"}, Product, lastProd);
    while (Busy && n < 40) begin
      case (PPSel)
        2'b00:   d = PPNeg ? 99 : 0;
        2'b01:   d = 1;
        2'b10:   d = 2;
        default: d = 99;
      endcase
      if (PPNeg && PPSel != 2'b00) d = -d;
      if (n < 17) digSum += d * (longint'(1) << (2 * n));
      if (Done) doneSeen++;
      if (n == glitch) begin
        Start  = 1'b1;
        Signed = ~sgn;
        A      = $urandom;
        B      = $urandom;
      end
      tick();
      Start = 1'b0;
      n++;
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'd17);
    chk({tag, "_done_in_run"}, 64'(doneSeen), 64'd0);
    chk({tag, "_digit_value"}, 64'(digSum), 64'(refMult(sgn, b)));
    chk({tag, "_done"}, 64'(Done), 64'd1);
    chk({tag, "_product"}, Product, expP);
    lastProd = expP;
  endtask

  initial begin
    Reset  = 1'b1;
    Start  = 1'b0;
    Signed = 1'b0;
    A      = '0;
    B      = '0;
    tick();
    tick();
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_product", Product, 64'd0);
    chk("rst_ppsel", 64'(PPSel), 64'd0);
    chk("rst_ppneg", 64'(PPNeg), 64'd0);
    Reset = 1'b0;
    tick();

    // Signed -1 * -1
    launch(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitResult("s_ones", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("s_ones_const", Product, 64'h0000_0000_0000_0001);
    tick();
    chk("s_ones_done_drop", 64'(Done), 64'd0);
    chk("s_ones_idle_busy", 64'(Busy), 64'd0);
    chk("idle_ppsel", 64'(PPSel), 64'd0);

    // Unsigned all-ones
    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitResult("u_ones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("u_ones_const", Product, 64'hFFFF_FFFE_0000_0001);
    tick();

    // Most negative squared
    launch(1'b1, 32'h8000_0000, 32'h8000_0000);
    waitResult("s_min", 1'b1, 32'h8000_0000, 32'h8000_0000, -1);
    chk("s_min_const", Product, 64'h4000_0000_0000_0000);
    tick();

    // 7 * -3
    launch(1'b1, 32'd7, 32'hFFFF_FFFD);
    waitResult("s_neg", 1'b1, 32'd7, 32'hFFFF_FFFD, -1);
    chk("s_neg_const", Product, 64'hFFFF_FFFF_FFFF_FFEB);
    tick();

    // 5 * 3 unsigned: explicit select trace
    launch(1'b0, 32'd5, 32'd3);
    chk("sel_prod_held", Product, lastProd);
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("sel_busy_%0d", k), 64'(Busy), 64'd1);
      chk($sformatf("sel_ppsel_%0d", k), 64'(PPSel), (k < 2) ? 64'd1 : 64'd0);
      chk($sformatf("sel_ppneg_%0d", k), 64'(PPNeg), (k == 0) ? 64'd1 : 64'd0);
      tick();
    end
    chk("sel_done", 64'(Done), 64'd1);
    chk("sel_product", Product, 64'd15);
    lastProd = 64'd15;
    tick();

    // Start re-asserted in RUN cycle 3 is ignored
    launch(1'b0, 32'd9, 32'd11);
    waitResult("ign", 1'b0, 32'd9, 32'd11, 3);
    chk("ign_const", Product, 64'd99);

    // Start held in the DONE cycle: back-to-back 2 * 3
    launch(1'b1, 32'd2, 32'd3);
    waitResult("b2b", 1'b1, 32'd2, 32'd3, -1);
    chk("b2b_const", Product, 64'd6);
    tick();

    // Reset in RUN cycle 5 aborts and clears Product
    launch(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int k = 0; k < 5; k++) tick();
    chk("abort_busy_before", 64'(Busy), 64'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_done", 64'(Done), 64'd0);
    chk("abort_product", Product, 64'd0);
    chk("abort_ppsel", 64'(PPSel), 64'd0);
    tick();
    chk("abort_stays_idle", 64'(Busy), 64'd0);
    lastProd = '0;

    // Randomized operations, mixing idle gaps and back-to-back starts
    for (int i = 0; i < 24; i++) begin
      logic        sgn;
      logic [31:0] ra;
      logic [31:0] rb;
      sgn = 1'($urandom_range(0, 1));
      ra  = pickOperand();
      rb  = pickOperand();
      launch(sgn, ra, rb);
      waitResult($sformatf("rnd%0d", i), sgn, ra, rb, -1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
